fifo_reader: RTL and testbench

FIFO_READER -- requirements
Module: fifo_reader

---
 rtl/fifo_reader.sv | 115 +++++++++++
 tb/tb_fifo_reader.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_reader.sv
// fifo_reader: pops an upstream FIFO with one-cycle read latency and delivers the
// words in pop order through a 2-entry skid buffer that absorbs downstream pauses.
module fifo_reader #(
    parameter int DATA_SIZE = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 fifo_empty,
    input  logic                 fifo_error,
    input  logic [DATA_SIZE-1:0] data_out_pop,
    input  logic                 downstream_pause,
    output logic                 read,
    output logic [DATA_SIZE-1:0] data_out,
    output logic                 valid_out,
    output logic                 reader_error,
    output logic [7:0]           pop_count
);

    typedef enum logic [1:0] {IDLE, ACTIVE, ERROR} state_t;

    state_t               state_q, state_d;
    logic                 rd_q, rd_d;
    logic [1:0]           occ_q, occ_d, occ_mid;
    logic [DATA_SIZE-1:0] skid0_q, skid0_d;
    logic [DATA_SIZE-1:0] skid1_q, skid1_d;
    logic [DATA_SIZE-1:0] data_out_q, data_out_d;
    logic                 valid_q, valid_d;
    logic                 err_q, err_d;
    logic [7:0]           count_q, count_d;

    logic [2:0]           fill;
    logic                 has_buf;
    logic                 emit;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (fifo_error)  state_d = ERROR;
                else if (enable) state_d = ACTIVE;
            end
            ACTIVE: begin
                if (fifo_error)   state_d = ERROR;
                else if (!enable) state_d = IDLE;
            end
            default: state_d = ERROR;
        endcase
    end

    // Words already buffered plus the one in flight must leave room for the next pop.
    assign fill    = {1'b0, occ_q} + {2'b00, rd_q};
    assign read    = reset && (state_q == ACTIVE) && !fifo_empty && !downstream_pause
                     && !fifo_error && (fill <= 3'd1);
    assign rd_d    = read;
    assign has_buf = (occ_q != 2'd0);
    assign emit    = !downstream_pause && (has_buf || rd_q);
    assign err_d   = err_q || (state_d == ERROR);

    always_comb begin
        skid0_d    = skid0_q;
        skid1_d    = skid1_q;
        data_out_d = data_out_q;
        valid_d    = 1'b0;
        count_d    = count_q;
        occ_mid    = occ_q;
        if (emit) begin
            valid_d    = 1'b1;
            count_d    = count_q + 8'd1;
            data_out_d = has_buf ? skid0_q : data_out_pop;
        end
        if (emit && has_buf) begin
            skid0_d = skid1_q;
            occ_mid = occ_q - 2'd1;
        end
        // An arriving word that was not bypassed joins the tail, behind any older word.
        if (rd_q && !(emit && !has_buf)) begin
            if (occ_mid == 2'd0) skid0_d = data_out_pop;
            else                 skid1_d = data_out_pop;
            occ_mid = occ_mid + 2'd1;
        end
        occ_d = occ_mid;
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            rd_q       <= 1'b0;
            occ_q      <= 2'd0;
            skid0_q    <= '0;
            skid1_q    <= '0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            count_q    <= 8'd0;
        end else begin
            state_q    <= state_d;
            rd_q       <= rd_d;
            occ_q      <= occ_d;
            skid0_q    <= skid0_d;
            skid1_q    <= skid1_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            count_q    <= count_d;
        end
    end

    assign data_out     = data_out_q;
    assign valid_out    = valid_q;
    assign reader_error = err_q;
    assign pop_count    = count_q;

endmodule

// File: tb/tb_fifo_reader.sv
// tb_fifo_reader: drives fifo_reader from a queue-backed FIFO model and checks every
// cycle against a queue-level reference of the pop/deliver rules.
module tb_fifo_reader;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       fifo_empty;
    logic       fifo_error;
    logic [9:0] data_out_pop;
    logic       downstream_pause;
    logic       read;
    logic [9:0] data_out;
    logic       valid_out;
    logic       reader_error;
    logic [7:0] pop_count;

    fifo_reader #(.DATA_SIZE(10)) dut (
        .clk              (clk),
        .reset            (reset),
        .enable           (enable),
        .fifo_empty       (fifo_empty),
        .fifo_error       (fifo_error),
        .data_out_pop     (data_out_pop),
        .downstream_pause (downstream_pause),
        .read             (read),
        .data_out         (data_out),
        .valid_out        (valid_out),
        .reader_error     (reader_error),
        .pop_count        (pop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    logic [9:0] fifo_q[$];
    bit         pop_req = 1'b0;
    logic [9:0] got[$];
    int         read_at[$];
    int         valid_at[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (pop_req && fifo_q.size() > 0) data_out_pop = fifo_q.pop_front();
        else                              data_out_pop = 10'($urandom);
        fifo_empty = (fifo_q.size() == 0);
    endtask

    task automatic push_word(input logic [9:0] w);
        fifo_q.push_back(w);
        fifo_empty = 1'b0;
    endtask

    // Reference: arrived-but-undelivered words form one ordered queue; the head leaves
    // on every unpaused cycle. Expectations are for the outputs after the next edge.
    typedef enum {M_IDLE, M_ACTIVE, M_ERROR} mstate_t;

    initial begin : compare
        mstate_t    m_state;
        logic [9:0] m_skid[$];
        logic [9:0] words[$];
        bit         m_rd, ref_ok, exp_valid, exp_err, exp_read;
        logic [9:0] exp_data;
        logic [7:0] exp_cnt;
        int         cyc;
        ref_ok = 1'b0;
        m_rd   = 1'b0;
        cyc    = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (ref_ok) begin
                check("valid_out", valid_out, exp_valid);
                check("data_out", data_out, exp_data);
                check("pop_count", pop_count, exp_cnt);
                check("reader_error", reader_error, exp_err);
                if (valid_out === 1'b1) begin
                    got.push_back(data_out);
                    valid_at.push_back(cyc);
                end
            end
            exp_read = reset && (m_state == M_ACTIVE) && !fifo_empty && !downstream_pause
                       && !fifo_error && (m_skid.size() + int'(m_rd) <= 1);
            if (ref_ok || !reset) check("read", read, exp_read);
            if (read === 1'b1) read_at.push_back(cyc);
            pop_req = (read === 1'b1);
            if (!reset) begin
                m_state   = M_IDLE;
                m_skid.delete();
                m_rd      = 1'b0;
                exp_valid = 1'b0;
                exp_data  = '0;
                exp_cnt   = 8'd0;
                exp_err   = 1'b0;
                ref_ok    = 1'b1;
            end else if (ref_ok) begin
                words = m_skid;
                if (m_rd) words.push_back(data_out_pop);
                exp_valid = 1'b0;
                if (!downstream_pause && words.size() > 0) begin
                    exp_data  = words.pop_front();
                    exp_valid = 1'b1;
                    exp_cnt   = exp_cnt + 8'd1;
                end
                check("skid_occupancy_le_2", words.size() <= 2, 1);
                m_skid = words;
                m_rd   = exp_read;
                if (m_state != M_ERROR && fifo_error) begin
                    m_state = M_ERROR;
                    exp_err = 1'b1;
                end else if (m_state == M_IDLE && enable) begin
                    m_state = M_ACTIVE;
                end else if (m_state == M_ACTIVE && !enable) begin
                    m_state = M_IDLE;
                end
            end
        end
    end

    initial begin : stimulus
        int rm, vm, nm, total;
        reset            = 1'b0;
        enable           = 1'b0;
        downstream_pause = 1'b0;
        fifo_error       = 1'b0;
        fifo_empty       = 1'b1;
        data_out_pop     = '0;
        repeat (3) tick();
        check("reset_valid_out", valid_out, 0);
        check("reset_data_out", data_out, 0);
        check("reset_pop_count", pop_count, 0);
        check("reset_reader_error", reader_error, 0);
        check("reset_read", read, 0);
        reset = 1'b1;

        // Streaming five preloaded words
        rm = read_at.size(); vm = got.size();
        for (int i = 1; i <= 5; i++) push_word(10'(i));
        total  = 5;
        enable = 1'b1;
        repeat (10) tick();
        check("stream_reads", read_at.size() - rm, 5);
        check("stream_words", got.size() - vm, 5);
        if (read_at.size() - rm == 5 && got.size() - vm == 5) begin
            check("stream_read_run", read_at[rm+4] - read_at[rm], 4);
            check("stream_latency", valid_at[vm] - read_at[rm], 2);
            check("stream_valid_run", valid_at[vm+4] - valid_at[vm], 4);
            for (int i = 0; i < 5; i++) check("stream_data", got[vm+i], i + 1);
        end
        check("stream_pop_count", pop_count, 5);

        // Three-cycle pause mid-stream
        rm = read_at.size(); vm = got.size();
        for (int i = 0; i < 10; i++) push_word(10'(12'h040 + i));
        total += 10;
        repeat (3) tick();
        downstream_pause = 1'b1;
        #1;
        check("pause_drops_read", read, 0);
        repeat (3) tick();
        downstream_pause = 1'b0;
        repeat (15) tick();
        check("pause_reads", read_at.size() - rm, 10);
        check("pause_words", got.size() - vm, 10);
        if (got.size() - vm == 10)
            for (int i = 0; i < 10; i++) check("pause_order", got[vm+i], 12'h040 + i);

        // Single word, then an empty FIFO
        rm = read_at.size(); vm = got.size();
        push_word(10'h155);
        total += 1;
        repeat (8) tick();
        check("empty_single_read", read_at.size() - rm, 1);
        check("empty_single_valid", got.size() - vm, 1);
        check("empty_word", got[got.size()-1], 10'h155);
        check("empty_read_low", read, 0);

        // Disable mid-stream, then resume
        rm = read_at.size(); vm = got.size();
        for (int i = 0; i < 20; i++) push_word(10'(12'h100 + i));
        total += 20;
        repeat (4) tick();
        enable = 1'b0;
        repeat (2) tick();
        nm = read_at.size();
        repeat (5) tick();
        check("disabled_no_reads", read_at.size(), nm);
        check("disable_inflight_delivered", got.size() - vm, read_at.size() - rm);
        check("disable_partial", (read_at.size() - rm) < 20, 1);
        enable = 1'b1;
        repeat (25) tick();
        check("disable_all_words", got.size() - vm, 20);
        if (got.size() - vm == 20)
            for (int i = 0; i < 20; i++) check("disable_order", got[vm+i], 12'h100 + i);
        check("pop_count_before_wrap", pop_count, total % 256);

        // 256 further deliveries bring pop_count back around
        vm = got.size();
        for (int i = 0; i < 256; i++) push_word(10'(i * 3));
        total += 256;
        repeat (270) tick();
        check("wrap_words", got.size() - vm, 256);
        check("pop_count_wrap", pop_count, total % 256);

        // Randomised traffic, then drain
        repeat (800) begin
            tick();
            downstream_pause = ($urandom_range(0, 3) == 0);
            enable           = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 1) == 1) begin
                push_word(10'($urandom));
                total++;
            end
        end
        downstream_pause = 1'b0;
        enable           = 1'b1;
        repeat (30) tick();
        check("random_drained", fifo_q.size(), 0);
        check("random_pop_count", pop_count, total % 256);

        // Reset with a word parked in the skid buffer
        for (int i = 0; i < 6; i++) push_word(10'(12'h200 + i));
        repeat (3) tick();
        downstream_pause = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        fifo_q.delete();
        fifo_empty = 1'b1;
        tick();
        check("midreset_valid_out", valid_out, 0);
        check("midreset_data_out", data_out, 0);
        check("midreset_pop_count", pop_count, 0);
        check("midreset_reader_error", reader_error, 0);
        check("midreset_read", read, 0);
        reset            = 1'b1;
        downstream_pause = 1'b0;
        vm = got.size();
        for (int i = 0; i < 3; i++) push_word(10'(12'h3a0 + i));
        repeat (10) tick();
        check("postreset_words", got.size() - vm, 3);
        if (got.size() - vm == 3)
            for (int i = 0; i < 3; i++) check("postreset_order", got[vm+i], 12'h3a0 + i);
        check("postreset_pop_count", pop_count, 3);

        // One-cycle FIFO error with a word in flight
        rm = read_at.size(); vm = got.size();
        for (int i = 0; i < 10; i++) push_word(10'(12'h050 + i));
        repeat (2) tick();
        fifo_error = 1'b1;
        nm = read_at.size();
        tick();
        fifo_error = 1'b0;
        repeat (20) tick();
        check("error_sticky", reader_error, 1);
        check("error_no_reads", read_at.size(), nm);
        check("error_inflight_delivered", got.size() - vm, read_at.size() - rm);
        check("error_read_low", read, 0);

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
